// File: rtl/riscv_memory.sv
// Unified instruction/data memory beside the core.
// Streams every word over a valid/ready dump port once the core halts.
module riscv_memory #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] DUMP_BASE = 32'h0
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     inst_addr,
  output logic [31:0]     inst,
  input  logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_in,
  output logic [0:3][7:0] mem_data_out,
  input  logic            mem_write_en,
  input  logic            halted,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [31:0]     dump_addr,
  output logic [31:0]     dump_data,
  output logic            dump_done,
  output logic            misalign_err
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    RUN,
    DUMP,
    DONE
  } state_e;

  logic [7:0]    lane_q [4][MEM_WORDS];
  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          mis_q, mis_d;

  logic [AW-1:0] iidx;
  logic [AW-1:0] didx;
  logic          store_ok;

  assign iidx = inst_addr[AW+1:2];
  assign didx = mem_addr[AW+1:2];

  function automatic logic [31:0] word_at(input logic [AW-1:0] i);
    return {lane_q[3][i], lane_q[2][i], lane_q[1][i], lane_q[0][i]};
  endfunction

  always_comb begin
    inst = word_at(iidx);
    mem_data_out = '0;
    for (int k = 0; k < 4; k++) begin
      mem_data_out[k] = lane_q[k][didx];
    end
  end

  assign store_ok = (state_q == RUN) && mem_write_en && !halted
                 && (mem_addr[1:0] == 2'b00) && !rst_b;

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (store_ok) begin
      for (int k = 0; k < 4; k++) begin
        lane_q[k][didx] <= mem_data_in[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mis_d   = mis_q;
    if (state_q == RUN && mem_write_en && mem_addr[1:0] != 2'b00) begin
      mis_d = 1'b1;
    end
    case (state_q)
      RUN: begin
        if (halted) begin
          state_d = DUMP;
          idx_d   = '0;
          addr_d  = DUMP_BASE;
          data_d  = word_at('0);
        end
      end
      DUMP: begin
        if (dump_ready) begin
          idx_d  = idx_q + AW'(1);
          addr_d = DUMP_BASE + (32'(idx_d) << 2);
          data_d = word_at(idx_d);
          if (idx_q == AW'(MEM_WORDS - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= RUN;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
    end
  end

  assign dump_valid   = (state_q == DUMP);
  assign dump_done    = (state_q == DONE);
  assign dump_addr    = addr_q;
  assign dump_data    = data_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_riscv_memory.sv
// Directed bench for riscv_memory: a 1024-word instance for
// load/store/wrap and a 4-word instance for the halt dump.
module tb_riscv_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // a_*: MEM_WORDS=1024 instance
  logic            a_rst;
  logic [31:0]     a_iaddr, a_inst, a_maddr;
  logic [0:3][7:0] a_din, a_dout;
  logic            a_we, a_halt, a_valid, a_ready, a_done, a_mis;
  logic [31:0]     a_daddr, a_ddata;

  // b_*: MEM_WORDS=4 instance
  logic            b_rst;
  logic [31:0]     b_iaddr, b_inst, b_maddr;
  logic [0:3][7:0] b_din, b_dout;
  logic            b_we, b_halt, b_valid, b_ready, b_done, b_mis;
  logic [31:0]     b_daddr, b_ddata;

  riscv_memory #(.MEM_WORDS(1024)) u_a (
    .clk(clk), .rst_b(a_rst),
    .inst_addr(a_iaddr), .inst(a_inst),
    .mem_addr(a_maddr), .mem_data_in(a_din),
    .mem_data_out(a_dout), .mem_write_en(a_we),
    .halted(a_halt), .dump_valid(a_valid),
    .dump_ready(a_ready), .dump_addr(a_daddr),
    .dump_data(a_ddata), .dump_done(a_done),
    .misalign_err(a_mis)
  );

  riscv_memory #(.MEM_WORDS(4)) u_b (
    .clk(clk), .rst_b(b_rst),
    .inst_addr(b_iaddr), .inst(b_inst),
    .mem_addr(b_maddr), .mem_data_in(b_din),
    .mem_data_out(b_dout), .mem_write_en(b_we),
    .halted(b_halt), .dump_valid(b_valid),
    .dump_ready(b_ready), .dump_addr(b_daddr),
    .dump_data(b_ddata), .dump_done(b_done),
    .misalign_err(b_mis)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lanes -> little-endian word
  function automatic logic [31:0] le(input logic [0:3][7:0] d);
    return {d[3], d[2], d[1], d[0]};
  endfunction

  initial begin
    a_rst = 1'b1; a_iaddr = '0; a_maddr = '0; a_din = '0;
    a_we = 1'b0; a_halt = 1'b0; a_ready = 1'b0;
    b_rst = 1'b1; b_iaddr = '0; b_maddr = '0; b_din = '0;
    b_we = 1'b0; b_halt = 1'b0; b_ready = 1'b0;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("rst_mis", 32'(a_mis), 32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_daddr", a_daddr, 32'h0);

    // basic store / load
    a_maddr = 32'h10; a_din = {8'h11, 8'h22, 8'h33, 8'h44}; a_we = 1'b1;
    tick();
    a_we = 1'b0; a_iaddr = 32'h10;
    #1;
    chk("ld_lanes", a_dout, 32'h11223344);
    chk("ld_inst", a_inst, 32'h44332211);

    // back-to-back stores: same-cycle read sees old data
    a_maddr = 32'h4; a_din = {4{8'h01}}; a_we = 1'b1;
    tick();
    a_din = {4{8'hAA}};
    #1;
    chk("b2b_old0", a_dout, 32'h01010101);
    tick();
    a_din = {4{8'hBB}};
    #1;
    chk("b2b_old1", a_dout, 32'hAAAAAAAA);
    tick();
    a_we = 1'b0;
    #1;
    chk("b2b_final", a_dout, 32'hBBBBBBBB);

    // misaligned store
    a_maddr = 32'h6; a_din = {4{8'h99}}; a_we = 1'b1;
    tick();
    a_we = 1'b0; a_maddr = 32'h4;
    #1;
    chk("mis_nowr", a_dout, 32'hBBBBBBBB);
    chk("mis_set", 32'(a_mis), 32'd1);
    for (int i = 0; i < 10; i++) begin
      a_maddr = 32'h20 + 32'(4 * i);
      a_din = {8'(i), 8'h5A, 8'hC3, 8'h7E};
      a_we = 1'b1;
      tick();
    end
    a_we = 1'b0; a_iaddr = 32'h2C;
    #1;
    chk("mis_sticky", 32'(a_mis), 32'd1);
    chk("al_store", a_inst, 32'h7EC35A03);
    a_rst = 1'b1;
    #1;
    chk("mis_clr", 32'(a_mis), 32'd0);
    // store attempted during reset is dropped
    a_maddr = 32'h20; a_din = {4{8'h66}}; a_we = 1'b1;
    tick();
    a_we = 1'b0; a_rst = 1'b0; a_iaddr = 32'h20;
    #1;
    chk("rst_nowr", a_inst, 32'h7EC35A00);
    a_iaddr = 32'h10;
    #1;
    chk("rst_keep", a_inst, 32'h44332211);

    // address wrap at 4*1024 bytes
    a_maddr = 32'h1000; a_din = {8'hEF, 8'hBE, 8'hAD, 8'hDE}; a_we = 1'b1;
    tick();
    a_we = 1'b0; a_iaddr = 32'h0; a_maddr = 32'h0;
    #1;
    chk("wrap_inst", a_inst, 32'hDEADBEEF);
    chk("wrap_data", le(a_dout), 32'hDEADBEEF);

    // dump on the 4-word instance
    for (int k = 0; k < 4; k++) begin
      b_maddr = 32'(4 * k); b_din = {8'(k), 8'h0, 8'h0, 8'h0}; b_we = 1'b1;
      tick();
    end
    b_we = 1'b0;
    #1;
    chk("pre_valid", 32'(b_valid), 32'd0);
    b_maddr = 32'h0; b_din = {4{8'hFF}}; b_we = 1'b1; b_halt = 1'b1;
    tick();
    b_we = 1'b0;
    #1;
    chk("halt_nowr", le(b_dout), 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d%0d_valid", k), 32'(b_valid), 32'd1);
      chk($sformatf("d%0d_addr", k), b_daddr, 32'(4 * k));
      chk($sformatf("d%0d_data", k), b_ddata, 32'(k));
      b_ready = 1'b0;
      tick();
      chk($sformatf("d%0d_hold_a", k), b_daddr, 32'(4 * k));
      chk($sformatf("d%0d_hold_d", k), b_ddata, 32'(k));
      b_ready = 1'b1;
      tick();
    end
    b_ready = 1'b0;
    #1;
    chk("dn_done", 32'(b_done), 32'd1);
    chk("dn_valid", 32'(b_valid), 32'd0);
    b_halt = 1'b0;
    tick();
    chk("dn_stay", 32'(b_done), 32'd1);

    // reset mid-dump
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0; b_halt = 1'b1;
    tick();
    chk("rd_start", 32'(b_valid), 32'd1);
    b_ready = 1'b1;
    tick(); tick();
    b_ready = 1'b0;
    chk("rd_mid", b_ddata, 32'd2);
    b_rst = 1'b1;
    #1;
    chk("rd_valid0", 32'(b_valid), 32'd0);
    chk("rd_daddr0", b_daddr, 32'h0);
    chk("rd_ddata0", b_ddata, 32'h0);
    b_halt = 1'b0;
    tick();
    b_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_iaddr = 32'(4 * k);
      #1;
      chk($sformatf("keep%0d", k), b_inst, 32'(k));
    end
    b_halt = 1'b1;
    tick();
    chk("re_valid", 32'(b_valid), 32'd1);
    chk("re_addr", b_daddr, 32'h0);
    chk("re_data", b_ddata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_memory.md
Name: riscv_memory

Overview:
- Unified instruction/data memory that answers the core's fetch and load/store interface. Serves `inst` for `inst_addr`. Serves 4-byte-lane loads and performs stores on `mem_addr`.
- Once the core raises `halted`, a dump FSM streams every memory word out over a valid/ready port so the bench can compare final memory state.
- Sits beside the core in the top-level; the core is the only initiator.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words stored; must be a power of two.
- DUMP_BASE, 32'h0, byte address reported on `dump_addr` for word 0.

Ports:
- clk  input  1  single clock, all state on posedge
- rst_b  input  1  asynchronous, active-high reset
- inst_addr  input  32  instruction fetch byte address from core
- inst  output  32  instruction word at inst_addr
- mem_addr  input  32  data byte address from core
- mem_data_in  input  4x8 ([0:3])  store data from core; lane k = byte at address+k
- mem_data_out  output  4x8 ([0:3])  load data to core; lane k = byte at address+k
- mem_write_en  input  1  store request for current cycle
- halted  input  1  core halted indication
- dump_valid  output  1  dump word available
- dump_ready  input  1  bench accepts dump word
- dump_addr  output  32  byte address of current dump word
- dump_data  output  32  current dump word, little-endian
- dump_done  output  1  all words dumped
- misalign_err  output  1  sticky: store attempted with mem_addr[1:0] != 0

Behaviour:
- Storage: four byte-lane arrays of MEM_WORDS entries. Word index = addr[log2(MEM_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo 4*MEM_WORDS. Contents are not cleared by reset.
- Reads: combinational, zero latency. `inst` is the little-endian word at the inst_addr index, with lane 0 in bits [7:0]. `mem_data_out[k]` is lane k at the mem_addr index. Low two address bits are ignored on reads.
- Stores happen on posedge clk only when all of the following hold:
  - state == RUN
  - mem_write_en == 1
  - halted == 0
  - mem_addr[1:0] == 0
  All four lanes are written. A read of the same address in the same cycle returns old data; the new data is visible the next cycle.
- Misaligned store (mem_write_en=1, mem_addr[1:0]!=0, state RUN): no write; misalign_err is set to 1 and stays set until reset.
- FSM states: RUN, DUMP, DONE. Reset state is RUN.
  - RUN -> DUMP: the first posedge with halted=1. A store presented in that same cycle is suppressed. The dump index is cleared to 0.
  - DUMP: dump_valid=1, dump_addr = DUMP_BASE + 4*idx, dump_data = word[idx].
    - On a posedge with dump_valid and dump_ready both 1, idx increments.
    - If idx == MEM_WORDS-1 at that handshake, go to DONE.
    - Outputs hold stable while dump_ready=0.
  - DONE: dump_valid=0 and dump_done=1. The FSM stays in DONE until reset.
  - Once in DUMP or DONE, halted falling is ignored and stores stay blocked.
- Reset (async, any state, including mid-dump) clears the following; memory contents are kept:
  - state=RUN
  - idx=0
  - dump_valid=0, dump_done=0, dump_addr=0, dump_data=0
  - misalign_err=0
- dump_addr and dump_data are registered, updated on entry to DUMP and on each handshake.
- Stores issued while rst_b is asserted are ignored.

Test Plan:
- Store mem_addr=0x10, bytes {0x11,0x22,0x33,0x44}, mem_write_en=1 for one cycle. Next cycle, read with mem_addr=0x10 -> mem_data_out={0x11,0x22,0x33,0x44}; inst_addr=0x10 -> inst=0x44332211.
- Store at 0x4 with 0xAA in every lane, then 0xBB in every lane, on back-to-back cycles -> same-cycle read returns prior data; final read = 0xBBBBBBBB.
- Store at mem_addr=0x6 -> memory word 1 unchanged; misalign_err=1 and stays 1 through 10 further aligned stores. Reset -> misalign_err=0.
- Address wrap with MEM_WORDS=1024: store 0xDEADBEEF at 0x1000 -> read at 0x0 returns 0xDEADBEEF.
- Preload words 0..3 = 0,1,2,3 with MEM_WORDS=4. Raise halted with mem_write_en=1 at 0x0 carrying 0xFF bytes:
  - the store is suppressed;
  - dump emits (0x0,0), (0x4,1), (0x8,2), (0xC,3), with dump_ready toggling 1/0 and outputs held during stalls;
  - dump_done=1 after the 4th handshake and dump_valid=0.
- Assert rst_b after the 2nd dump handshake -> dump_valid=0 immediately. Memory still reads 0,1,2,3. Re-raising halted restarts the dump at dump_addr=0x0.
